// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor controller.
// Operands pass LSB first through one NAND-gate full-adder cell, one bit per
// clock. Subtraction adds the inverted op_b with the carry preset to 1.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN adds a registered signed-overflow
// output 'ovf'.
module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned    CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_sh_q;
  logic [WIDTH-1:0]  b_sh_q;
  logic              carry_q;
  logic [CntW-1:0]   cnt_q;
  logic              fa_sum;
  logic              fa_cout;

  // The only arithmetic in the block: one bit slice per clock.
  nand_full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Controller FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
            a_sh_q  <= op_a;
            // Two's complement subtract: a + ~b + 1
            b_sh_q  <= op_b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          // Result fills from the top; after WIDTH shifts bit 0 is the LSB sum.
          result  <= {fa_sum, result[WIDTH-1:1]};
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            cout    <= fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
            // carry_q here is the carry into the MSB slice.
            ovf     <= carry_q ^ fa_cout;
`endif
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// 1-bit full adder built from nine 2-input NAND gates.
module nand_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic n1, n2, n3, n4, n5, n6, n7;

  assign n1   = ~(a & b);
  assign n2   = ~(a & n1);
  assign n3   = ~(b & n1);
  assign n4   = ~(n2 & n3);   // a ^ b
  assign n5   = ~(n4 & cin);
  assign n6   = ~(n4 & n5);
  assign n7   = ~(cin & n5);
  assign sum  = ~(n6 & n7);
  assign cout = ~(n1 & n5);

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl (WIDTH=8).
module tb_serial_addsub_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             sub   = 1'b0;
  logic [WIDTH-1:0] op_a  = '0;
  logic [WIDTH-1:0] op_b  = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // Present operands at a falling edge; returns #1 after the accepting edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input bit hold);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Called right after the accepting edge; done_cycle is the 1-based cycle in
  // which done was seen (0 if never within the bound).
  task automatic wait_done(output int done_cycle, output int busy_cycles);
    done_cycle  = 0;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cycle = k + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int dc, bc;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    op_a  = 8'h35;
    op_b  = 8'h4A;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_accept_busy: got %b want 1", busy); end
    wait_done(dc, bc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    int dc, bc;
    launch(8'h35, 8'h4A, 1'b0, 1'b0);
    wait_done(dc, bc);
    checks++; if (dc != 9) begin errors++; $display("FAIL add_done_cycle: got %0d want 9", dc); end
    checks++; if (bc != 8) begin errors++; $display("FAIL add_busy_cycles: got %0d want 8", bc); end
    checks++; if (result !== 8'h7F) begin errors++; $display("FAIL add_result: got %h want 7f", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout: got %b want 0", cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b want 0", ovf); end
`endif
    op_a = 8'hAA;
    op_b = 8'h55;
    sub  = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_single: got %b want 0", done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result !== 8'h7F) begin errors++; $display("FAIL add_result_hold: got %h want 7f", result); end
  endtask

  task automatic test_add_wrap();
    int dc, bc;
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(dc, bc);
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL wrap_result: got %h want 00", result); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL wrap_cout: got %b want 1", cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b want 0", ovf); end
`endif
    @(posedge clk);
    #1;
    launch(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(dc, bc);
    checks++; if (result !== 8'h80) begin errors++; $display("FAIL sovf_result: got %h want 80", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sovf_cout: got %b want 0", cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sovf_ovf: got %b want 1", ovf); end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_sub();
    int dc, bc;
    launch(8'h10, 8'h01, 1'b1, 1'b0);
    wait_done(dc, bc);
    checks++; if (result !== 8'h0F) begin errors++; $display("FAIL sub_result: got %h want 0f", result); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub_cout: got %b want 1", cout); end
    @(posedge clk);
    #1;
    launch(8'h01, 8'h02, 1'b1, 1'b0);
    wait_done(dc, bc);
    checks++; if (result !== 8'hFF) begin errors++; $display("FAIL borrow_result: got %h want ff", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL borrow_cout: got %b want 0", cout); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [7:0] cap_res = 8'h00;
    logic       cap_cout = 1'b1;
    launch(8'h35, 8'h4A, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // Now in RUN cycle 3: a different request must be dropped.
    @(negedge clk);
    op_a  = 8'hFF;
    op_b  = 8'hFF;
    sub   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          cap_res  = result;
          cap_cout = cout;
        end
      end
      @(posedge clk);
      #1;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
    checks++; if (cap_res !== 8'h7F) begin errors++; $display("FAIL ignore_result: got %h want 7f", cap_res); end
    checks++; if (cap_cout !== 1'b0) begin errors++; $display("FAIL ignore_cout: got %b want 0", cap_cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    int dc, bc;
    int pulses = 0;
    int busys  = 0;
    launch(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL midrst_result: got %h want 00", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b want 0", cout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
      if (busy) busys++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", pulses); end
    checks++; if (busys != 0) begin errors++; $display("FAIL midrst_idle: got %0d want 0", busys); end
    launch(8'h02, 8'h03, 1'b0, 1'b0);
    wait_done(dc, bc);
    checks++; if (dc != 9) begin errors++; $display("FAIL postrst_done_cycle: got %0d want 9", dc); end
    checks++; if (result !== 8'h05) begin errors++; $display("FAIL postrst_result: got %h want 05", result); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    int pulses = 0;
    int first = -1;
    int prev = -1;
    int bad_gap = 0;
    int consec = 0;
    int bad_res = 0;
    logic prev_done = 1'b0;
    launch(8'h10, 8'h01, 1'b1, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (first < 0) first = k;
        if (prev >= 0 && (k - prev) != 10) bad_gap++;
        if (prev_done) consec++;
        if (result !== 8'h0F) bad_res++;
        prev = k;
      end
      prev_done = done;
    end
    start = 1'b0;
    checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
    checks++; if (first != 8) begin errors++; $display("FAIL b2b_first: got %0d want 8", first); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_gap: got %0d bad want 0", bad_gap); end
    checks++; if (consec != 0) begin errors++; $display("FAIL b2b_consec: got %0d want 0", consec); end
    checks++; if (bad_res != 0) begin errors++; $display("FAIL b2b_result: got %0d bad want 0", bad_res); end
    wait_done(dc, bc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_wrap();
    test_sub();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = add, 1 = subtract (op_a - op_b); sampled with start.
REQ-006 op_a  input  WIDTH  first operand; sampled with start.
REQ-007 op_b  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  single-cycle pulse; result/cout valid.
REQ-010 result  output  WIDTH  sum or difference, unsigned modulo 2^WIDTH.
REQ-011 cout  output  1  final carry; for sub, 1 = no borrow.

Function
REQ-012 The block SHALL compute through exactly one instance of the team's 1-bit NAND-gate full adder cell, one bit per cycle, LSB first; no wider adder SHALL be inferred.
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after WIDTH RUN cycles, DONE->IDLE unconditionally after one cycle.
REQ-014 On the IDLE edge with start=1: op_a and (op_b XOR {WIDTH{sub}}) SHALL load into shift registers, carry register SHALL load sub, bit counter SHALL clear.
REQ-015 Each RUN cycle: adder inputs = LSBs of both shift registers and carry register; sum bit SHALL shift into result register MSB; carry register SHALL take adder cout; counter increments.
REQ-016 Counter width SHALL be ceil(log2(WIDTH))+1 bits; RUN exits when counter = WIDTH-1 is processed, no wrap-around.
REQ-017 done SHALL be high exactly in DONE, i.e. the (WIDTH+1)th cycle after the start edge; busy SHALL be high exactly in RUN.
REQ-018 result and cout SHALL be stable from DONE until the next accepted start; they SHALL NOT show partial values outside RUN.
REQ-019 start while in RUN or DONE SHALL be ignored (not queued); start held high across DONE->IDLE SHALL begin a new operation on the following edge.
REQ-020 Operand inputs SHALL be don't-care except on the accepting edge.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, cout=0, carry/counter/shift registers to 0, regardless of clock.
REQ-022 Reset mid-RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-023 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro SERIAL_ADDSUB_OVF_EN: when defined, output ovf (1 bit) SHALL exist, equal to (carry into MSB) XOR (carry out of MSB) of the last operation, registered in DONE, held like result, reset to 0.
REQ-025 When SERIAL_ADDSUB_OVF_EN is undefined, ovf port and its register SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-026 Add: op_a=0x35, op_b=0x4A, sub=0 -> done on 9th cycle after start, result=0x7F, cout=0, busy high 8 cycles.
REQ-027 Add wrap: 0xFF + 0x01 -> result=0x00, cout=1; with OVF_EN ovf=0; 0x7F + 0x01 -> result=0x80, ovf=1.
REQ-028 Sub: 0x10 - 0x01 -> result=0x0F, cout=1; 0x01 - 0x02 -> result=0xFF, cout=0.
REQ-029 start pulsed at RUN cycle 3 with different operands -> ignored; first operation's result unchanged, exactly one done pulse.
REQ-030 rst_n low at RUN cycle 4 -> outputs zero immediately, IDLE after release, no done; next 0x02+0x03 -> result=0x05.
REQ-031 start held high continuously -> back-to-back operations, done every 10 cycles, never two consecutive done cycles.
